// File: rtl/decoder2x4_pulse.sv
// Sequential 2-to-4 decoder: latches a 2-bit code on a valid/ready handshake and
// drives the matching one-hot line for PULSE_LEN cycles, followed by one all-zero gap cycle.
`timescale 1ns/1ps
module decoder2x4_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a1,
  input  logic             a0,
  output logic             y3,
  output logic             y2,
  output logic             y1,
  output logic             y0,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] code_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] TIMER_LOAD = 4'(PULSE_LEN - 1);

  state_t           state_q, state_d;
  logic [3:0]       timer_q, timer_d;
  logic [3:0]       y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & en & in_ready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_DRIVE;
          timer_d     = TIMER_LOAD;
          y_d         = 4'b0001 << {a1, a0};
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          count_d     = count_q + CNT_W'(1);
        end
      end
      S_DRIVE: begin
        // A low enable truncates the pulse but still leaves the clean gap cycle.
        if (!en || timer_q == 4'd0) begin
          state_d     = S_GAP;
          y_d         = 4'b0000;
          out_valid_d = 1'b0;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        y_d         = 4'b0000;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= 4'd0;
      y_q         <= 4'b0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign y3         = y_q[3];
  assign y2         = y_q[2];
  assign y1         = y_q[1];
  assign y0         = y_q[0];
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign code_count = count_q;

endmodule
